// File: rtl/fe_pipe_regs.sv
// Front-end pipeline register bank: fetch PC, F/D and D/E registers with stall/flush/redirect control.
// Optional FE_PIPE_PERF_CNT_EN adds saturating stall and redirect cycle counters.

package fe_pipe_regs_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_LOAD  = 4'd11,
        ALU_STORE = 4'd12
    } alu_ctrl_e;

endpackage

module fe_pipe_regs
    import fe_pipe_regs_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_fd_i,
    input  logic            flush_d_i,
    input  logic            flush_e_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic [31:0]     instrF_i,
    output logic [XLEN-1:0] pcF_o,
    output logic [XLEN-1:0] pcD_o,
    output logic [31:0]     instrD_o,
    output logic            validD_o,
    input  logic [4:0]      rs1D_addr_i,
    input  logic [4:0]      rs2D_addr_i,
    input  logic [4:0]      rdD_addr_i,
    input  logic            rd_wr_enaD_i,
    input  alu_ctrl_e       opD_i,
    input  logic [XLEN-1:0] rs1D_data_i,
    input  logic [XLEN-1:0] rs2D_data_i,
    input  logic [XLEN-1:0] immD_i,
    output logic [4:0]      rs1E_addr_o,
    output logic [4:0]      rs2E_addr_o,
    output logic [4:0]      rdE_addr_o,
    output logic            rd_wr_enaE_o,
    output alu_ctrl_e       opE_o,
    output logic [XLEN-1:0] rs1E_data_o,
    output logic [XLEN-1:0] rs2E_data_o,
    output logic [XLEN-1:0] immE_o,
    output logic [XLEN-1:0] pcE_o,
    output logic            validE_o
`ifdef FE_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
`endif
);

    localparam int unsigned RA_W      = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            rd_wr_ena;
        alu_ctrl_e       op;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            valid;
    } de_t;

    // Bubble op is ADD (non-load) so a bubble can never raise a load-use stall.
    localparam de_t DE_BUBBLE = '{
        rs1: '0, rs2: '0, rd: '0, rd_wr_ena: 1'b0, op: ALU_ADD,
        rs1_data: '0, rs2_data: '0, imm: '0, pc: '0, valid: 1'b0
    };

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pcD_q, pcD_d;
    logic [31:0]     instrD_q, instrD_d;
    logic            validD_q, validD_d;
    de_t             de_q, de_d;

    // Next-state: redirect beats stall on PC, flush beats stall on F/D; D/E never stalls.
    always_comb begin
        pc_d     = pc_q + XLEN'(4);
        pcD_d    = pc_q;
        instrD_d = instrF_i;
        validD_d = 1'b1;
        de_d     = '{
            rs1: rs1D_addr_i, rs2: rs2D_addr_i, rd: rdD_addr_i,
            rd_wr_ena: rd_wr_enaD_i, op: opD_i,
            rs1_data: rs1D_data_i, rs2_data: rs2D_data_i, imm: immD_i,
            pc: pcD_q, valid: validD_q
        };

        if (stall_fd_i) begin
            pc_d     = pc_q;
            pcD_d    = pcD_q;
            instrD_d = instrD_q;
            validD_d = validD_q;
        end
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end
        if (flush_d_i) begin
            pcD_d    = '0;
            instrD_d = NOP_INSTR;
            validD_d = 1'b0;
        end
        if (flush_e_i) begin
            de_d = DE_BUBBLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            pcD_q    <= '0;
            instrD_q <= NOP_INSTR;
            validD_q <= 1'b0;
            de_q     <= DE_BUBBLE;
        end else begin
            pc_q     <= pc_d;
            pcD_q    <= pcD_d;
            instrD_q <= instrD_d;
            validD_q <= validD_d;
            de_q     <= de_d;
        end
    end

    assign pcF_o        = pc_q;
    assign pcD_o        = pcD_q;
    assign instrD_o     = instrD_q;
    assign validD_o     = validD_q;
    assign rs1E_addr_o  = de_q.rs1;
    assign rs2E_addr_o  = de_q.rs2;
    assign rdE_addr_o   = de_q.rd;
    assign rd_wr_enaE_o = de_q.rd_wr_ena;
    assign opE_o        = de_q.op;
    assign rs1E_data_o  = de_q.rs1_data;
    assign rs2E_data_o  = de_q.rs2_data;
    assign immE_o       = de_q.imm;
    assign pcE_o        = de_q.pc;
    assign validE_o     = de_q.valid;

`ifdef FE_PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: stalls that were not overridden by a redirect, and redirect cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_fd_i && !redirect_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (redirect_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
